// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared types and helpers for the fb_swap_master frame-buffer
//                slice: controller state encoding, buffer index type and the
//                "third index" helper used by triple buffering.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int c_IDX_W  = 2;
  localparam int c_DROP_W = 16;

  typedef logic [c_IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

  // For two distinct indices taken from {0,1,2}, the remaining one is
  // 3 - a - b (the 2-bit wrap never matters for legal inputs).
  function automatic buf_idx_t third_index(input buf_idx_t a, input buf_idx_t b);
    return buf_idx_t'(2'd3 - a - b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fb_bank
//  Description : One colour-index frame buffer of PIXELS x DATA_W with a single
//                write port and NUM_READ registered read ports (latency 1).
//  Revision    : 1.0 - initial release
//  Ports       : clock   - pixel clock
//                i_we    - write enable (address already range-checked)
//                i_waddr - write address
//                i_wdata - write data
//                i_raddr - packed per-channel read addresses
//                o_rdata - packed per-channel registered read data; a channel
//                          holds its previous value for out-of-range addresses
// ============================================================================
module fb_bank
  import fb_pkg::*;
#(
  parameter int PIXELS   = 307200,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 4,
  parameter int NUM_READ = 2
) (
  input  logic                         clock,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [NUM_READ*ADDR_W-1:0]   i_raddr,
  output logic [NUM_READ*DATA_W-1:0]   o_rdata
);

  // Memory is indexed with just enough bits to cover PIXELS entries.
  localparam int              c_MEM_AW  = $clog2(PIXELS);
  localparam logic [ADDR_W:0] c_PIX_LIM = (ADDR_W+1)'(PIXELS);

  logic [DATA_W-1:0] r_mem [PIXELS];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr[c_MEM_AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_READ; i++) begin
      if ({1'b0, i_raddr[i*ADDR_W +: ADDR_W]} < c_PIX_LIM) begin
        o_rdata[i*DATA_W +: DATA_W] <= r_mem[i_raddr[i*ADDR_W +: c_MEM_AW]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_swap_master.sv
`default_nettype none
// ============================================================================
//  Module      : fb_swap_master
//  Description : Double/triple frame-buffer controller. Displays the front
//                buffer on NUM_READ read channels, lets two sprite ports draw
//                into the back buffer, clears every new back buffer and swaps
//                on the vsync edge once the renderer reports frame_done.
//  Revision    : 1.0 - initial release
//  Ports       : clock, reset            - pixel clock, sync active-high reset
//                vsync                   - global vsync
//                rd_addr / rd_data       - packed read channels, latency 1
//                wr1_*/wr2_*             - sprite write ports (wr2 has priority)
//                frame_done              - back buffer complete pulse
//                fb_resetting            - back buffer clear in progress
//                swap_pulse              - front index changed this cycle
//                front_idx / back_idx    - displayed / drawn buffer
//                frames_dropped          - saturating dropped-frame count
// ============================================================================
module fb_swap_master
  import fb_pkg::*;
#(
  parameter int                NUM_BUFFERS  = 2,
  parameter int                NUM_READ     = 2,
  parameter int                PIXELS       = 307200,
  parameter int                ADDR_W       = 19,
  parameter int                DATA_W       = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR  = '0,
  parameter logic              VSYNC_ACTIVE = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [ADDR_W-1:0]          wr2_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [DATA_W-1:0]          wr2_data,
  input  logic                       wr1_en,
  input  logic                       wr2_en,
  input  logic                       frame_done,
  output logic                       fb_resetting,
  output logic                       swap_pulse,
  output logic [c_IDX_W-1:0]         front_idx,
  output logic [c_IDX_W-1:0]         back_idx,
  output logic [c_DROP_W-1:0]        frames_dropped
);

  localparam bit                c_TRIPLE    = (NUM_BUFFERS == 3);
  localparam logic [ADDR_W:0]   c_PIX_LIM   = (ADDR_W+1)'(PIXELS);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(PIXELS - 1);

  fb_state_t             r_state, w_state_nx;
  logic [ADDR_W-1:0]     r_clear_addr, w_clear_nx;
  buf_idx_t              r_front, w_front_nx;
  buf_idx_t              r_back, w_back_nx;
  buf_idx_t              r_pend, w_pend_nx;
  logic                  r_pend_v, w_pend_v_nx;
  logic                  r_swap, w_swap_nx;
  logic [c_DROP_W-1:0]   r_drops, w_drops_nx;
  logic                  r_vsync_q, r_edge, w_edge;

  logic                  w_wr_en;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [DATA_W-1:0]     w_wr_data;
  logic                  w_wr1_ok, w_wr2_ok;

  buf_idx_t              r_rd_sel;
  logic [NUM_READ-1:0]   r_rd_oob, w_rd_oob;
  logic                  r_rd_live;
  logic [NUM_READ*DATA_W-1:0] w_bank_q [NUM_BUFFERS];
  logic [NUM_READ*DATA_W-1:0] w_sel_q;

  // The detected edge is registered once more before the FSM acts on it, so
  // a swap lands two clocks after vsync moves.
  assign w_edge = (vsync == VSYNC_ACTIVE) && (r_vsync_q != VSYNC_ACTIVE);

  always_comb begin
    w_state_nx  = r_state;
    w_clear_nx  = r_clear_addr;
    w_front_nx  = r_front;
    w_back_nx   = r_back;
    w_pend_nx   = r_pend;
    w_pend_v_nx = r_pend_v;
    w_swap_nx   = 1'b0;
    w_drops_nx  = r_drops;

    // Triple mode: the edge promotes a waiting frame regardless of state,
    // and is resolved before a same-cycle frame_done is looked at.
    if (c_TRIPLE && r_edge && r_pend_v) begin
      w_front_nx  = r_pend;
      w_pend_v_nx = 1'b0;
      w_swap_nx   = 1'b1;
    end

    case (r_state)
      CLEAR: begin
        if (r_clear_addr == c_LAST_ADDR) begin
          w_state_nx = DRAW;
          w_clear_nx = '0;
        end else begin
          w_clear_nx = r_clear_addr + 1'b1;
        end
      end
      DRAW: begin
        if (frame_done) begin
          if (c_TRIPLE) begin
            // A pending frame still unshown is overwritten: count the drop.
            // third_index then naturally recycles that stale buffer.
            if (w_pend_v_nx && (r_drops != '1)) begin
              w_drops_nx = r_drops + 1'b1;
            end
            w_pend_nx   = r_back;
            w_pend_v_nx = 1'b1;
            w_back_nx   = third_index(w_front_nx, r_back);
            w_state_nx  = CLEAR;
          end else begin
            w_state_nx = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (r_edge) begin
          w_front_nx = r_back;
          w_back_nx  = r_front;
          w_swap_nx  = 1'b1;
          w_state_nx = CLEAR;
        end
      end
      default: w_state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    r_vsync_q <= vsync;
    if (reset) begin
      r_state      <= CLEAR;
      r_clear_addr <= '0;
      r_front      <= buf_idx_t'(0);
      r_back       <= buf_idx_t'(1);
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_swap       <= 1'b0;
      r_drops      <= '0;
      r_edge       <= 1'b0;
      r_rd_sel     <= '0;
      r_rd_oob     <= '0;
      r_rd_live    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_clear_addr <= w_clear_nx;
      r_front      <= w_front_nx;
      r_back       <= w_back_nx;
      r_pend       <= w_pend_nx;
      r_pend_v     <= w_pend_v_nx;
      r_swap       <= w_swap_nx;
      r_drops      <= w_drops_nx;
      r_edge       <= w_edge;
      // Bank choice is frozen with the address so an in-flight read
      // finishes from the bank that was front when it was issued.
      r_rd_sel     <= r_front;
      r_rd_oob     <= w_rd_oob;
      r_rd_live    <= 1'b1;
    end
  end

  // Single bank write port: clear engine, else wr2, else wr1. Two draws to
  // different addresses in one cycle keep only wr2.
  assign w_wr1_ok = wr1_en && ({1'b0, wr1_addr} < c_PIX_LIM);
  assign w_wr2_ok = wr2_en && ({1'b0, wr2_addr} < c_PIX_LIM);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_clear_addr;
    w_wr_data = CLEAR_COLOR;
    if (r_state == CLEAR) begin
      w_wr_en = 1'b1;
    end else if (r_state == DRAW) begin
      if (w_wr2_ok) begin
        w_wr_en   = 1'b1;
        w_wr_addr = wr2_addr;
        w_wr_data = wr2_data;
      end else if (w_wr1_ok) begin
        w_wr_en   = 1'b1;
        w_wr_addr = wr1_addr;
        w_wr_data = wr1_data;
      end
    end
  end

  for (genvar b = 0; b < NUM_BUFFERS; b++) begin : g_bank
    fb_bank #(
      .PIXELS   (PIXELS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_READ (NUM_READ)
    ) u_bank (
      .clock   (clock),
      .i_we    (w_wr_en && (r_back == buf_idx_t'(b))),
      .i_waddr (w_wr_addr),
      .i_wdata (w_wr_data),
      .i_raddr (rd_addr),
      .o_rdata (w_bank_q[b])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      w_rd_oob[i] = !({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < c_PIX_LIM);
    end
  end

  always_comb begin
    w_sel_q = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      if (r_rd_sel == buf_idx_t'(b)) begin
        w_sel_q = w_bank_q[b];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (!r_rd_live) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (r_rd_oob[i]) begin
        rd_data[i*DATA_W +: DATA_W] = CLEAR_COLOR;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = w_sel_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign fb_resetting   = (r_state == CLEAR);
  assign swap_pulse     = r_swap;
  assign front_idx      = r_front;
  assign back_idx       = r_back;
  assign frames_dropped = r_drops;

endmodule
`default_nettype wire
